// File: rtl/alu_2.sv
// alu_2: sequential 8-bit ALU fed by a shared operand bus.
// Operand A is taken on the start edge and operand B on the next edge.
// Add and subtract finish in one EXEC cycle.
// Signed multiply uses radix-2 Booth over 8 EXEC cycles, then emits the high byte and the low byte.
// Optional feature macro: ALU_2_DIV_EN. When it is defined, op=3 is an unsigned restoring divide
// that emits the remainder and then the quotient. When it is not defined, op=3 returns 0x00.
// The start request port is named "start" because "begin" is a reserved word.
module alu_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] inbus,
  output logic [7:0] outbus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadB,
    StExec,
    StOutHi,
    StOutLo,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  // Shared accumulators.
  // For multiply: accp is the Booth partial product and accq is the multiplier.
  // For divide: accp is the remainder and accq is the dividend/quotient.
  logic [8:0]  accp_q, accp_d;
  logic [7:0]  accq_q, accq_d;
  logic        accx_q, accx_d;
  logic [7:0]  out_q, out_d;

  logic [8:0]  mcand;
  logic [8:0]  booth_sum;

  assign outbus = out_q;

  // Booth step: add or subtract the sign-extended multiplicand according to {q0, q-1}
  always_comb begin
    mcand = {a_q[7], a_q};
    case ({accq_q[0], accx_q})
      2'b01:   booth_sum = accp_q + mcand;
      2'b10:   booth_sum = accp_q - mcand;
      default: booth_sum = accp_q;
    endcase
  end

`ifdef ALU_2_DIV_EN
  logic [8:0] div_r;
  logic [8:0] div_rem;
  logic       div_ge;

  // Restoring divide step.
  // A zero divisor always succeeds, which yields Q=0xFF and R=A.
  always_comb begin
    div_r   = {accp_q[7:0], accq_q[7]};
    div_ge  = (div_r >= {1'b0, b_q});
    div_rem = div_ge ? (div_r - {1'b0, b_q}) : div_r;
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    accp_d  = accp_q;
    accq_d  = accq_q;
    accx_d  = accx_q;
    out_d   = out_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = inbus;
          state_d = StLoadB;
        end
      end
      StLoadB: begin
        b_d    = inbus;
        op_d   = op;
        cnt_d  = 3'd0;
        accp_d = 9'd0;
        accx_d = 1'b0;
        // Divide shifts the dividend out of accq; multiply scans the multiplier there
        accq_d  = (op == 2'd3) ? a_q : inbus;
        state_d = StExec;
      end
      StExec: begin
        case (op_q)
          2'd0: begin
            out_d   = a_q + b_q;
            state_d = StDone;
          end
          2'd1: begin
            out_d   = a_q - b_q;
            state_d = StDone;
          end
          2'd2: begin
            {accp_d, accq_d, accx_d} = {booth_sum[8], booth_sum, accq_q};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = StOutHi;
          end
          default: begin
`ifdef ALU_2_DIV_EN
            accp_d = div_rem;
            accq_d = {accq_q[6:0], div_ge};
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = StOutHi;
`else
            out_d   = 8'h00;
            state_d = StDone;
`endif
          end
        endcase
      end
      StOutHi: begin
        // Holds product[15:8] for multiply, or the remainder for divide
        out_d   = accp_q[7:0];
        state_d = StOutLo;
      end
      StOutLo: begin
        // Holds product[7:0] for multiply, or the quotient for divide
        out_d   = accq_q;
        state_d = StDone;
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      op_q    <= 2'd0;
      cnt_q   <= 3'd0;
      accp_q  <= 9'd0;
      accq_q  <= 8'h00;
      accx_q  <= 1'b0;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      accp_q  <= accp_d;
      accq_q  <= accq_d;
      accx_q  <= accx_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_alu_2.sv
// tb_alu_2: directed and randomized checks of alu_2 against an arithmetic reference model.
module tb_alu_2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'd0;
  logic [7:0] inbus = 8'h00;
  logic [7:0] outbus;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] last_out = 8'h00;

  alu_2 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .inbus  (inbus),
    .outbus (outbus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    n_vec++;
    assert (outbus === exp)
    else begin
      n_bad++;
      $error("FAIL %s: outbus=%h expected=%h", tag, outbus, exp);
    end
  endtask

`ifdef ALU_2_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  // Reference model: returns {first byte, second byte} for two-byte ops, {0, result} otherwise
  function automatic logic [15:0] model(input logic [1:0] o, input logic [7:0] a,
                                        input logic [7:0] b);
    int sa, sb, p;
    logic [15:0] r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = 16'h0000;
    case (o)
      2'd0: r = {8'h00, 8'((int'(a) + int'(b)) % 256)};
      2'd1: r = {8'h00, 8'((int'(a) - int'(b) + 256) % 256)};
      2'd2: begin
        p = sa * sb;
        r = p[15:0];
      end
      default: begin
        if (!DivEn) r = 16'h0000;
        else if (b == 8'h00) r = {a, 8'hFF};
        else r = {8'(a % b), 8'(a / b)};
      end
    endcase
    return r;
  endfunction

  function automatic bit is_long(input logic [1:0] o);
    return (o == 2'd2) || (o == 2'd3 && DivEn);
  endfunction

  // One complete operation. Start stays high throughout and for 'hold' extra cycles in DONE.
  task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input string tag);
    logic [15:0] exp;
    exp   = model(o, a, b);
    start = 1'b1;
    inbus = a;
    op    = 2'($urandom);
    tick();
    check({tag, "_keep1"}, last_out);
    inbus = b;
    op    = o;
    tick();
    check({tag, "_keep2"}, last_out);
    inbus = 8'($urandom);
    op    = 2'($urandom);
    if (is_long(o)) begin
      for (int i = 0; i < 8; i++) begin
        tick();
        inbus = 8'($urandom);
        op    = 2'($urandom);
      end
      check({tag, "_exec"}, last_out);
      tick();
      check({tag, "_hi"}, exp[15:8]);
      tick();
      check({tag, "_lo"}, exp[7:0]);
    end else begin
      tick();
      check({tag, "_res"}, exp[7:0]);
    end
    last_out = exp[7:0];
    for (int i = 0; i < hold; i++) begin
      inbus = 8'($urandom);
      op    = 2'($urandom);
      tick();
      check({tag, "_hold"}, last_out);
    end
    start = 1'b0;
    tick();
    check({tag, "_idle"}, last_out);
  endtask

  initial begin
    #12;
    check("reset_out", 8'h00);
    rst_n = 1'b1;
    tick();
    check("post_reset", 8'h00);

    run_op(2'd0, 8'd24, 8'd31, 0, "add_24_31");
    run_op(2'd0, 8'd200, 8'd56, 1, "add_wrap");
    run_op(2'd1, 8'd99, 8'd55, 0, "sub_99_55");
    run_op(2'd1, 8'h80, 8'd1, 0, "sub_m128_1");
    run_op(2'd1, 8'hEC, 8'd10, 0, "sub_m20_10");
    run_op(2'd2, 8'd32, 8'hE7, 0, "mul_32_m25");
    run_op(2'd2, 8'hE0, 8'hE7, 0, "mul_m32_m25");
    run_op(2'd2, 8'h80, 8'h80, 0, "mul_m128_m128");
    run_op(2'd3, 8'hF0, 8'h60, 0, "div_f0_60");
    run_op(2'd3, 8'h14, 8'h00, 0, "div_by_zero");

    // Start held high after DONE must not retrigger
    run_op(2'd2, 8'd7, 8'd9, 6, "hold_high");

    for (int k = 0; k < 40; k++) begin
      logic [1:0] ro;
      logic [7:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op(ro, ra, rb, int'($urandom_range(0, 3)), "rand");
    end

    // Asynchronous reset during the 4th EXEC cycle of a multiply
    run_op(2'd0, 8'd5, 8'd5, 0, "pre_rst");
    start = 1'b1;
    inbus = 8'h11;
    tick();
    inbus = 8'h22;
    op    = 2'd2;
    tick();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("rst_async", 8'h00);
    start = 1'b0;
    tick();
    check("rst_held", 8'h00);
    #2;
    rst_n    = 1'b1;
    last_out = 8'h00;
    repeat (12) tick();
    check("rst_no_resume", 8'h00);
    run_op(2'd0, 8'd1, 8'd2, 0, "add_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
